// File: rtl/xdatabus_responder.sv
// xdatabus_responder: round-robin databus slave serving N_PORTS masters from one word RAM.
// Each granted beat spends one cycle each in IDLE, ACCESS and RESP; ready/rdata are registered.
module xdatabus_responder #(
    parameter int N_PORTS = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_PORTS-1:0]          s_databus_valid,
    output logic [N_PORTS-1:0]          s_databus_ready,
    input  logic [N_PORTS*ADDR_W-1:0]   s_databus_addr,
    input  logic [N_PORTS*DATA_W-1:0]   s_databus_wdata,
    input  logic [N_PORTS*DATA_W/8-1:0] s_databus_wstrb,
    output logic [N_PORTS*DATA_W-1:0]   s_databus_rdata
);
    localparam int SW = DATA_W / 8;
    localparam int PW = N_PORTS > 1 ? $clog2(N_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                           state;
    logic [PW-1:0]                    last, grant, pick;
    logic [N_PORTS-1:0]               vld, ready_q;
    logic [N_PORTS-1:0][ADDR_W-1:0]   port_addr;
    logic [N_PORTS-1:0][DATA_W-1:0]   port_wdata, rdata_q;
    logic [N_PORTS-1:0][SW-1:0]       port_wstrb;
    logic [ADDR_W-1:0]                addr;
    logic [DATA_W-1:0]                wdata;
    logic [SW-1:0]                    wstrb;
    logic [DATA_W-1:0]                mem [2**ADDR_W];

    // Unpack the MSB-first buses into port-indexed arrays
    for (genvar i = 0; i < N_PORTS; i++) begin : g_port
        assign vld[i]        = s_databus_valid[N_PORTS-1-i];
        assign port_addr[i]  = s_databus_addr[N_PORTS*ADDR_W-1-i*ADDR_W -: ADDR_W];
        assign port_wdata[i] = s_databus_wdata[N_PORTS*DATA_W-1-i*DATA_W -: DATA_W];
        assign port_wstrb[i] = s_databus_wstrb[N_PORTS*SW-1-i*SW -: SW];
        assign s_databus_ready[N_PORTS-1-i] = ready_q[i];
        assign s_databus_rdata[N_PORTS*DATA_W-1-i*DATA_W -: DATA_W] = rdata_q[i];
    end

    // Descending scan so the port closest after last overwrites farther ones
    always_comb begin
        pick = last;
        for (int k = N_PORTS; k >= 1; k--)
            if (vld[PW'((int'(last) + k) % N_PORTS)]) pick = PW'((int'(last) + k) % N_PORTS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            last    <= PW'(N_PORTS - 1);
            grant   <= '0;
            addr    <= '0;
            wdata   <= '0;
            wstrb   <= '0;
            ready_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: if (|vld) begin
                    grant <= pick;
                    addr  <= port_addr[pick];
                    wdata <= port_wdata[pick];
                    wstrb <= port_wstrb[pick];
                    state <= ACCESS;
                end
                ACCESS: begin
                    ready_q[grant] <= 1'b1;
                    rdata_q[grant] <= wstrb == '0 ? mem[addr] : '0;
                    state          <= RESP;
                end
                RESP: begin
                    ready_q <= '0;
                    rdata_q <= '0;
                    last    <= grant;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gated by the async-reset state, so a reset before the ACCESS edge leaves RAM untouched
    always_ff @(posedge clk)
        if (state == ACCESS)
            for (int b = 0; b < SW; b++)
                if (wstrb[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
endmodule

// File: tb/tb_xdatabus_responder.sv
// tb_xdatabus_responder: randomized and directed bench for xdatabus_responder.
// A transaction-level model (grant edge, access one edge later, response visible until the next edge) predicts every cycle.
module tb_xdatabus_responder;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int SW = DW / 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        bit            drop;
    } req_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    valid, ready;
    logic [N*AW-1:0] addr_bus;
    logic [N*DW-1:0] wdata_bus, rdata_bus;
    logic [N*SW-1:0] wstrb_bus;

    xdatabus_responder #(.N_PORTS(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s_databus_valid(valid),
        .s_databus_ready(ready),
        .s_databus_addr(addr_bus),
        .s_databus_wdata(wdata_bus),
        .s_databus_wstrb(wstrb_bus),
        .s_databus_rdata(rdata_bus)
    );

    always #5 clk = ~clk;

    req_t          q [N][$];
    req_t          cur [N];
    bit            busy [N];
    bit            pin_valid [N];
    logic [AW-1:0] pin_addr [N];
    logic [DW-1:0] pin_wdata [N];
    logic [SW-1:0] pin_wstrb [N];

    always_comb begin
        valid     = '0;
        addr_bus  = '0;
        wdata_bus = '0;
        wstrb_bus = '0;
        for (int p = 0; p < N; p++) begin
            valid[N-1-p]                 = pin_valid[p];
            addr_bus[N*AW-1-p*AW -: AW]  = pin_addr[p];
            wdata_bus[N*DW-1-p*DW -: DW] = pin_wdata[p];
            wstrb_bus[N*SW-1-p*SW -: SW] = pin_wstrb[p];
        end
    end

    logic [DW-1:0]          mdl [2**AW];
    int                     last_p = N - 1;
    bit                     txn;
    int                     t_grant, t_port;
    req_t                   t_req;
    int                     n;
    logic [N-1:0]           exp_ready, got_ready;
    logic [N-1:0][DW-1:0]   exp_rdata, got_rdata;
    bit                     rand_on;
    int                     seen[$], seen_t[$];
    logic [DW-1:0]          seen_d[$];
    int                     checks, errors;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic req_t mk(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s, input bit drop);
        req_t r;
        r.addr  = a;
        r.wdata = d;
        r.wstrb = s;
        r.drop  = drop;
        return r;
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        return $urandom_range(1) != 0 ? AW'(32'h3F0 + $urandom_range(15)) : AW'($urandom_range(15));
    endfunction

    function automatic req_t rnd_req();
        return mk(rnd_addr(), $urandom, $urandom_range(9) < 4 ? '0 : SW'($urandom_range(15)), $urandom_range(7) == 0);
    endfunction

    function automatic bit pending();
        bit b = txn;
        for (int p = 0; p < N; p++) b = b | busy[p] | (q[p].size() != 0);
        return b;
    endfunction

    task automatic model_reset();
        txn       = 1'b0;
        last_p    = N - 1;
        exp_ready = '0;
        exp_rdata = '0;
    endtask

    // Round-robin from the spec: first valid port after the last one served
    task automatic model_edge();
        bit found = 1'b0;
        exp_ready = '0;
        exp_rdata = '0;
        if (rst_n) begin
            if (txn && n == t_grant + 1) begin
                exp_ready[t_port] = 1'b1;
                exp_rdata[t_port] = t_req.wstrb == '0 ? mdl[t_req.addr] : '0;
                for (int b = 0; b < SW; b++)
                    if (t_req.wstrb[b]) mdl[t_req.addr][8*b +: 8] = t_req.wdata[8*b +: 8];
            end else if (txn && n == t_grant + 2) begin
                last_p = t_port;
                txn    = 1'b0;
            end else if (!txn) begin
                for (int k = 1; k <= N; k++)
                    if (!found && pin_valid[(last_p + k) % N]) begin
                        found  = 1'b1;
                        t_port = (last_p + k) % N;
                    end
                if (found) begin
                    t_req   = mk(pin_addr[t_port], pin_wdata[t_port], pin_wstrb[t_port], cur[t_port].drop);
                    t_grant = n;
                    txn     = 1'b1;
                end
            end
        end
    endtask

    task automatic masters_update();
        for (int p = 0; p < N; p++) begin
            if (exp_ready[p]) begin
                busy[p]      = 1'b0;
                pin_valid[p] = 1'b0;
            end
            if (txn && t_grant == n && t_port == p && cur[p].drop) begin
                pin_valid[p] = 1'b0;
                pin_addr[p]  = AW'($urandom);
                pin_wdata[p] = $urandom;
                pin_wstrb[p] = SW'($urandom);
            end
            if (!busy[p] && q[p].size() != 0) begin
                cur[p]       = q[p].pop_front();
                busy[p]      = 1'b1;
                pin_valid[p] = 1'b1;
                pin_addr[p]  = cur[p].addr;
                pin_wdata[p] = cur[p].wdata;
                pin_wstrb[p] = cur[p].wstrb;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        n++;
        model_edge();
        @(negedge clk);
        for (int p = 0; p < N; p++) begin
            got_ready[p] = ready[N-1-p];
            got_rdata[p] = rdata_bus[N*DW-1-p*DW -: DW];
            if (got_ready[p]) begin
                seen.push_back(p);
                seen_t.push_back(n);
                seen_d.push_back(got_rdata[p]);
            end
        end
        check("ready", 128'(got_ready), 128'(exp_ready));
        check("rdata", 128'(got_rdata), 128'(exp_rdata));
        if (rand_on)
            for (int p = 0; p < N; p++)
                if (q[p].size() < 2 && $urandom_range(5) == 0) q[p].push_back(rnd_req());
        masters_update();
    endtask

    task automatic drain();
        int i = 0;
        while (i < 3000 && pending()) begin
            step();
            i++;
        end
        check("drain", 128'(pending()), 128'(0));
    endtask

    // Reset lands mid-cycle so the asynchronous clear of ready can be observed at once
    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_ready", 128'(ready), 128'(0));
        check("rst_rdata", 128'(rdata_bus), 128'(0));
        repeat (3) step();
        rst_n = 1'b1;
        seen.delete();
        seen_t.delete();
        seen_d.delete();
    endtask

    initial begin
        int rel, pos3, cnt3, i;
        logic [DW-1:0] w6, d3;
        for (int p = 0; p < N; p++) begin
            pin_addr[p]  = '0;
            pin_wdata[p] = '0;
            pin_wstrb[p] = '0;
        end
        // T1: all ports valid during reset, port 0 answers first
        for (int p = 0; p < N; p++) q[p].push_back(mk(AW'(32'h3F0 + p), $urandom, 4'hF, 1'b0));
        do_reset();
        rel = n;
        drain();
        check("t1_first_port", 128'(seen.size() > 0 ? seen[0] : 99), 128'(0));
        check("t1_latency", 128'(seen.size() > 0 ? seen_t[0] - rel : 99), 128'(2));
        // Preload every address the random phase may touch
        for (int a = 0; a < 32; a++) q[a % N].push_back(mk(AW'(a < 16 ? a : 1008 + a - 16), $urandom, 4'hF, 1'b0));
        drain();
        // T2: write then read at the top address
        seen_d.delete();
        q[1].push_back(mk(10'h3FF, 32'hDEADBEEF, 4'hF, 1'b0));
        q[1].push_back(mk(10'h3FF, 32'h0, 4'h0, 1'b0));
        drain();
        check("t2_wr_rdata", 128'(seen_d.size() > 0 ? seen_d[0] : 32'hX), 128'(0));
        check("t2_rd_rdata", 128'(seen_d.size() > 1 ? seen_d[1] : 32'hX), 128'(32'hDEADBEEF));
        // T3: byte strobes merge into the old word
        seen_d.delete();
        q[1].push_back(mk(10'd5, 32'h11223344, 4'hF, 1'b0));
        q[1].push_back(mk(10'd5, 32'hAABBCCDD, 4'h5, 1'b0));
        q[1].push_back(mk(10'd5, 32'h0, 4'h0, 1'b0));
        drain();
        check("t3_strobe", 128'(seen_d.size() > 2 ? seen_d[2] : 32'hX), 128'(32'h11BB33DD));
        // T4: all ports held -> strict rotation spaced 3 cycles
        do_reset();
        for (int p = 0; p < N; p++) begin
            q[p].push_back(mk(rnd_addr(), 32'h0, 4'h0, 1'b0));
            q[p].push_back(mk(rnd_addr(), 32'h0, 4'h0, 1'b0));
        end
        drain();
        for (int k = 0; k < 5; k++) check("t4_order", 128'(seen.size() > k ? seen[k] : 99), 128'(k % N));
        for (int k = 0; k < 4; k++) check("t4_spacing", 128'(seen.size() > k + 1 ? seen_t[k+1] - seen_t[k] : 99), 128'(3));
        // T5: ports 0 and 2 alternate; port 3 joins after two grants
        seen.delete();
        for (int k = 0; k < 4; k++) begin
            q[0].push_back(mk(rnd_addr(), 32'h0, 4'h0, 1'b0));
            q[2].push_back(mk(rnd_addr(), 32'h0, 4'h0, 1'b0));
        end
        i = 0;
        while (i < 100 && seen.size() < 2) begin
            step();
            i++;
        end
        q[3].push_back(mk(rnd_addr(), 32'h0, 4'h0, 1'b0));
        drain();
        pos3 = 99;
        foreach (seen[k]) if (seen[k] == 3 && pos3 == 99) pos3 = k;
        check("t5_first", 128'(seen.size() > 1 ? seen[0] : 99), 128'(0));
        check("t5_second", 128'(seen.size() > 1 ? seen[1] : 99), 128'(2));
        check("t5_port3_within2", 128'(pos3 <= 3), 128'(1));
        // T6: reset during RESP abandons the beat but keeps its write
        w6 = $urandom;
        q[1].push_back(mk(10'h3F5, w6, 4'hF, 1'b0));
        i = 0;
        while (i < 20 && !got_ready[1]) begin
            step();
            i++;
        end
        check("t6_resp_reached", 128'(got_ready[1]), 128'(1));
        q[2].push_back(mk(rnd_addr(), 32'h0, 4'h0, 1'b0));
        q[0].push_back(mk(rnd_addr(), 32'h0, 4'h0, 1'b0));
        q[3].push_back(mk(10'h3F5, 32'h0, 4'h0, 1'b1));
        do_reset();
        drain();
        check("t6_first_after_rst", 128'(seen.size() > 0 ? seen[0] : 99), 128'(0));
        cnt3 = 0;
        d3   = '0;
        foreach (seen[k]) if (seen[k] == 3) begin
            cnt3++;
            d3 = seen_d[k];
        end
        check("t6_drop_ready_once", 128'(cnt3), 128'(1));
        check("t6_write_kept", 128'(d3), 128'(w6));
        // Random traffic against the model
        rand_on = 1'b1;
        repeat (600) step();
        rand_on = 1'b0;
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
